semaforo_control: RTL and testbench

Traffic-light controller for a two-street intersection; it consumes the interval durations held in the timing-parameter register bank. Each cycle it drives the 2-bit `intervalo` select to the bank and reads back the 4-bit `valor` duration, which is combinational on `intervalo`. It loads that duration into an internal seconds countdown and sequences the main-street, side-street and optional pedestrian lights.

---
 rtl/semaforo_pkg.sv | 73 +++++++
 rtl/temporizador_intervalo.sv | 31 +++
 rtl/semaforo_control.sv | 105 ++++++++++
 tb/tb_semaforo_control.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared state encoding, bank select codes, light codes
// and the state-to-outputs decode used by semaforo_control.
// Build option: SEMAFORO_WALK_EN adds the pedestrian WALK state.
package semaforo_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [2:0] {
    ST_MAIN_GRN,
    ST_MAIN_EXT,
    ST_MAIN_YEL,
    ST_SIDE_GRN,
    ST_SIDE_YEL
`ifdef SEMAFORO_WALK_EN
    , ST_WALK
`endif
  } estado_t;

  typedef struct packed {
    logic [1:0] intervalo;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk;
  } salidas_t;

  function automatic salidas_t decode(estado_t st);
    salidas_t s;
    s.intervalo = INT_BASE;
    s.main_l    = LIGHT_GRN;
    s.side_l    = LIGHT_RED;
    s.walk      = 1'b0;
    unique case (st)
      ST_MAIN_GRN: begin
        s.intervalo = INT_BASE;
      end
      ST_MAIN_EXT: begin
        s.intervalo = INT_EXT;
      end
      ST_MAIN_YEL: begin
        s.intervalo = INT_YEL;
        s.main_l    = LIGHT_YEL;
      end
      ST_SIDE_GRN: begin
        s.intervalo = INT_EXT;
        s.main_l    = LIGHT_RED;
        s.side_l    = LIGHT_GRN;
      end
      ST_SIDE_YEL: begin
        s.intervalo = INT_YEL;
        s.main_l    = LIGHT_RED;
        s.side_l    = LIGHT_YEL;
      end
`ifdef SEMAFORO_WALK_EN
      ST_WALK: begin
        s.intervalo = INT_EXT;
        s.main_l    = LIGHT_RED;
        s.walk      = 1'b1;
      end
`endif
      default: begin
        s.intervalo = INT_BASE;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/temporizador_intervalo.sv
// temporizador_intervalo: seconds countdown for one light interval.
// Ports: clk, reset_n, load (capture valor), tick_1hz, valor,
// expire (one-cycle pulse on the tick that ends the interval).
module temporizador_intervalo #(
  parameter int TIMER_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               tick_1hz,
  input  logic [TIMER_W-1:0] valor,
  output logic               expire
);

  logic [TIMER_W-1:0] timer;

  // A count of 0 or 1 ends on the next tick, so 0 acts as 1.
  assign expire = !load && tick_1hz &&
                  (timer <= TIMER_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (load) begin
      timer <= valor;
    end else if (tick_1hz && !expire) begin
      timer <= timer - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/semaforo_control.sv
// semaforo_control: two-street traffic-light FSM driven by a parameter bank.
// Ports: clk, reset_n, tick_1hz, sensor_principal, walk_request, valor in;
// intervalo (bank select), main_light, side_light, walk_light out.
// Build option: SEMAFORO_WALK_EN enables the walk latch and WALK state.
module semaforo_control
  import semaforo_pkg::*;
#(
  parameter int TIMER_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_1hz,
  input  logic               sensor_principal,
  input  logic               walk_request,
  input  logic [TIMER_W-1:0] valor,
  output logic [1:0]         intervalo,
  output logic [2:0]         main_light,
  output logic [2:0]         side_light,
  output logic               walk_light
);

  estado_t  state;
  estado_t  nxt;
  salidas_t sal;
  logic     load;
  logic     expire;

`ifdef SEMAFORO_WALK_EN
  logic walk_pend;
`endif

  temporizador_intervalo #(
    .TIMER_W (TIMER_W)
  ) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .tick_1hz (tick_1hz),
    .valor    (valor),
    .expire   (expire)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_MAIN_GRN: nxt = sensor_principal ?
                         ST_MAIN_EXT : ST_MAIN_YEL;
      ST_MAIN_EXT: nxt = ST_MAIN_YEL;
`ifdef SEMAFORO_WALK_EN
      ST_MAIN_YEL: nxt = walk_pend ?
                         ST_WALK : ST_SIDE_GRN;
      ST_WALK:     nxt = ST_SIDE_GRN;
`else
      ST_MAIN_YEL: nxt = ST_SIDE_GRN;
`endif
      ST_SIDE_GRN: nxt = ST_SIDE_YEL;
      ST_SIDE_YEL: nxt = ST_MAIN_GRN;
      default:     nxt = ST_MAIN_GRN;
    endcase
    sal = decode(nxt);
  end

  // Outputs move with the state so they never see an input directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_MAIN_GRN;
      load       <= 1'b1;
      intervalo  <= INT_BASE;
      main_light <= LIGHT_GRN;
      side_light <= LIGHT_RED;
    end else begin
      load <= expire;
      if (expire) begin
        state      <= nxt;
        intervalo  <= sal.intervalo;
        main_light <= sal.main_l;
        side_light <= sal.side_l;
      end
    end
  end

`ifdef SEMAFORO_WALK_EN
  // Entering WALK consumes the request, even one arriving that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      walk_pend  <= 1'b0;
      walk_light <= 1'b0;
    end else begin
      if (expire) begin
        walk_light <= sal.walk;
      end
      if (expire && nxt == ST_WALK) begin
        walk_pend <= 1'b0;
      end else if (walk_request) begin
        walk_pend <= 1'b1;
      end
    end
  end
`else
  logic unused_walk;
  assign unused_walk = walk_request ^ sal.walk;
  assign walk_light  = 1'b0;
`endif

endmodule

// File: tb/tb_semaforo_control.sv
// tb_semaforo_control: directed interval table, corner sequences and
// randomized run against a phase-level reference model.
module tb_semaforo_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       sensor_principal = 1'b0;
  logic       walk_request = 1'b0;
  logic [3:0] valor;
  logic [1:0] intervalo;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;

  int tbase = 6;
  int text  = 3;
  int tyel  = 2;
  int total = 0;
  int bad   = 0;

`ifdef SEMAFORO_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  semaforo_control dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .tick_1hz         (tick_1hz),
    .sensor_principal (sensor_principal),
    .walk_request     (walk_request),
    .valor            (valor),
    .intervalo        (intervalo),
    .main_light       (main_light),
    .side_light       (side_light),
    .walk_light       (walk_light)
  );

  always #5 clk = ~clk;

  // parameter bank stub
  always_comb begin
    valor = 4'd0;
    case (intervalo)
      2'b00:   valor = 4'(tbase);
      2'b01:   valor = 4'(text);
      2'b10:   valor = 4'(tyel);
      default: valor = 4'd0;
    endcase
  end

  // phases: 0 MG, 1 ME, 2 MY, 3 SG, 4 SY, 5 WALK
  int m_ph;
  int m_left;
  bit m_fresh;
  bit m_latch;

  function automatic int next_ph(int ph, bit s, bit l);
    case (ph)
      0:       return s ? 1 : 2;
      1:       return 2;
      2:       return (WALK_EN && l) ? 5 : 3;
      3:       return 4;
      4:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int exp_out(int ph);
    case (ph)
      0:       return {2'b00, 3'b001, 3'b100, 1'b0};
      1:       return {2'b01, 3'b001, 3'b100, 1'b0};
      2:       return {2'b10, 3'b010, 3'b100, 1'b0};
      3:       return {2'b01, 3'b100, 3'b001, 1'b0};
      4:       return {2'b10, 3'b100, 3'b010, 1'b0};
      default: return {2'b01, 3'b100, 3'b100, 1'b1};
    endcase
  endfunction

  function automatic int bank_of(int ph);
    case (ph)
      0:       return tbase;
      2, 4:    return tyel;
      default: return text;
    endcase
  endfunction

  function automatic int cur();
    return {intervalo, main_light, side_light, walk_light};
  endfunction

  task automatic model_reset();
    m_ph = 0;
    m_left = 0;
    m_fresh = 1'b1;
    m_latch = 1'b0;
  endtask

  task automatic model_edge();
    bit entering;
    entering = 1'b0;
    if (m_fresh) begin
      m_left = bank_of(m_ph);
      if (m_left < 1) m_left = 1;
      m_fresh = 1'b0;
    end else if (tick_1hz) begin
      if (m_left > 1) begin
        m_left--;
      end else begin
        m_ph = next_ph(m_ph, sensor_principal, m_latch);
        m_fresh = 1'b1;
        entering = (m_ph == 5);
      end
    end
    if (entering) m_latch = 1'b0;
    else if (walk_request && WALK_EN) m_latch = 1'b1;
  endtask

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", cur(), exp_out(m_ph));
  endtask

  // Count ticks until the lights change; first cycle is the load cycle.
  task automatic measure(input bit tol, input int chg_at,
                         output int n);
    int start;
    start = cur();
    n = 0;
    tick_1hz = tol;
    step();
    tick_1hz = 1'b0;
    walk_request = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (chg_at > 0 && n == chg_at) begin
        tbase = 9;
        tyel = 0;
      end
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      n++;
      if (cur() != start) break;
      step();
    end
  endtask

  typedef struct {
    string      name;
    bit         s;
    bit         w;
    logic [8:0] o;
    int         ticks;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, bit s, bit w,
                              int ph, int t);
    vec_t v;
    v.name = nm;
    v.s = s;
    v.w = w;
    v.o = 9'(exp_out(ph));
    v.ticks = t;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    vq.push_back(mk("mg0", 0, 0, 0, 6));
    vq.push_back(mk("my0", 0, 0, 2, 2));
    vq.push_back(mk("sg0", 0, 0, 3, 3));
    vq.push_back(mk("sy0", 0, 0, 4, 2));
    vq.push_back(mk("mg_s", 1, 0, 0, 6));
    vq.push_back(mk("me_s", 1, 0, 1, 3));
    vq.push_back(mk("my_s", 1, 0, 2, 2));
    vq.push_back(mk("sg_w", 0, 1, 3, 3));
    vq.push_back(mk("sy1", 0, 0, 4, 2));
    vq.push_back(mk("mg1", 0, 0, 0, 6));
    vq.push_back(mk("my1", 0, 0, 2, 2));
    if (WALK_EN) begin
      vq.push_back(mk("walk", 0, 0, 5, 3));
    end
    vq.push_back(mk("sg1", 0, 0, 3, 3));
    vq.push_back(mk("sy2", 0, 0, 4, 2));
    vq.push_back(mk("mg2", 0, 0, 0, 6));
    vq.push_back(mk("my2", 0, 0, 2, 2));
    vq.push_back(mk("sg2", 0, 0, 3, 3));

    repeat (2) @(posedge clk);
    #1;
    chk("reset out", cur(), 9'b00_001_100_0);
    reset_n = 1'b1;

    foreach (vq[k]) begin
      sensor_principal = vq[k].s;
      walk_request = vq[k].w;
      chk({vq[k].name, " out"}, cur(), int'(vq[k].o));
      measure(1'b0, 0, n);
      chk({vq[k].name, " len"}, n, vq[k].ticks);
    end
    sensor_principal = 1'b0;

    // async reset in the middle of SIDE_YELLOW
    chk("sy pre", cur(), exp_out(4));
    step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async rst", cur(), 9'b00_001_100_0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold", cur(), 9'b00_001_100_0);
    reset_n = 1'b1;

    // tick on the load cycle is ignored
    measure(1'b1, 0, n);
    chk("tol mg", n, 6);
    measure(1'b0, 0, n);
    chk("my a", n, 2);
    measure(1'b0, 0, n);
    chk("sg a", n, 3);
    measure(1'b0, 0, n);
    chk("sy a", n, 2);
    // bank change mid-interval: tbase 9, tyel 0
    measure(1'b0, 2, n);
    chk("mg chg", n, 6);
    measure(1'b0, 0, n);
    chk("my zero", n, 1);
    measure(1'b0, 0, n);
    chk("sg b", n, 3);
    measure(1'b0, 0, n);
    chk("sy zero", n, 1);
    measure(1'b0, 0, n);
    chk("mg nine", n, 9);
    tbase = 6;
    tyel = 2;

    for (int i = 0; i < 3000; i++) begin
      tick_1hz = ($urandom_range(2) == 0);
      if ($urandom_range(7) == 0)
        sensor_principal = $urandom_range(1);
      walk_request = ($urandom_range(15) == 0);
      if ($urandom_range(63) == 0) tbase = $urandom_range(15);
      if ($urandom_range(63) == 0) text = $urandom_range(15);
      if ($urandom_range(63) == 0) tyel = $urandom_range(15);
      if ($urandom_range(599) == 0) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("rnd rst", cur(), 9'b00_001_100_0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
